// File: rtl/csr_serializer_pkg.sv
// Shared types and constants for the CSR/vector-config serialiser.
// Dispatch uses the uop encodings to decide which ops must be routed here.
package csr_serializer_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_HEAD   = 3'd1,
        S_ISSUE       = 3'd2,
        S_WAIT_RES    = 3'd3,
        S_WAIT_COMMIT = 3'd4,
        S_HOLDOFF     = 3'd5
    } csr_ser_state_t;

    localparam logic [4:0] UOP_CSRRW    = 5'b11000;
    localparam logic [4:0] UOP_CSRRS    = 5'b11001;
    localparam logic [4:0] UOP_CSRRC    = 5'b11010;
    localparam logic [4:0] UOP_CSRRWI   = 5'b11011;
    localparam logic [4:0] UOP_CSRRSI   = 5'b11100;
    localparam logic [4:0] UOP_CSRRCI   = 5'b11101;
    localparam logic [4:0] UOP_MRET     = 5'b11110;
    localparam logic [4:0] UOP_VSETVLI  = 5'b10000;
    localparam logic [4:0] UOP_VSETVL   = 5'b10001;
    localparam logic [4:0] UOP_VSETIVLI = 5'b10010;

    localparam int CSR_HOLDOFF_DEFAULT = 2;
    localparam int HOLDOFF_W           = 3;

    function automatic logic is_serialized_uop(input logic [4:0] uop);
        return ((uop >= UOP_CSRRW) && (uop <= UOP_MRET)) ||
               ((uop >= UOP_VSETVLI) && (uop <= UOP_VSETIVLI));
    endfunction

endpackage

// File: rtl/csr_serializer.sv
// Holds one CSR/vcfg op until it reaches the ROB head, issues it once, waits
// for its result and commit, then keeps the front end stalled for a holdoff.
module csr_serializer
    import csr_serializer_pkg::*;
#(
    parameter int TICKET_W    = 3,
    parameter int PC_W        = 32,
    parameter int HOLDOFF_CYC = CSR_HOLDOFF_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TICKET_W-1:0] in_ticket,
    input  logic                rob_head_valid,
    input  logic [TICKET_W-1:0] rob_head_ticket,
    output logic                csr_issue_valid,
    output logic [TICKET_W-1:0] csr_issue_ticket,
    input  logic                csr_done,
    input  logic [TICKET_W-1:0] csr_done_ticket,
    input  logic                csr_branch,
    input  logic [PC_W-1:0]     csr_branch_pc,
    input  logic                commit_valid,
    input  logic [TICKET_W-1:0] commit_ticket,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic                fe_stall,
    output logic                busy
);

    csr_ser_state_t         state_q, state_d;
    logic [TICKET_W-1:0]    ticket_q, ticket_d;
    logic                   redir_flag_q, redir_flag_d;
    logic [PC_W-1:0]        redir_pc_q, redir_pc_d;
    logic [HOLDOFF_W-1:0]   holdoff_cnt_q, holdoff_cnt_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]        redirect_pc_q, redirect_pc_d;

    logic head_hit;
    logic done_hit;
    logic commit_hit;

    assign head_hit   = rob_head_valid && (rob_head_ticket == ticket_q);
    assign done_hit   = csr_done && (csr_done_ticket == ticket_q);
    assign commit_hit = commit_valid && (commit_ticket == ticket_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            ticket_q         <= '0;
            redir_flag_q     <= 1'b0;
            redir_pc_q       <= '0;
            holdoff_cnt_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            ticket_q         <= ticket_d;
            redir_flag_q     <= redir_flag_d;
            redir_pc_q       <= redir_pc_d;
            holdoff_cnt_q    <= holdoff_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // The redirect register is only loaded from a commit, so a flush in the
    // cycle after commit cannot cancel a redirect that is already in flight.
    always_comb begin
        state_d          = state_q;
        ticket_d         = ticket_q;
        redir_flag_d     = redir_flag_q;
        redir_pc_d       = redir_pc_q;
        holdoff_cnt_d    = holdoff_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        if (flush) begin
            state_d       = S_IDLE;
            redir_flag_d  = 1'b0;
            holdoff_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ticket_d     = in_ticket;
                        redir_flag_d = 1'b0;
                        state_d      = S_WAIT_HEAD;
                    end
                end
                S_WAIT_HEAD: begin
                    if (head_hit) state_d = S_ISSUE;
                end
                S_ISSUE, S_WAIT_RES: begin
                    state_d = S_WAIT_RES;
                    if (done_hit) begin
                        redir_flag_d = csr_branch;
                        if (csr_branch) redir_pc_d = csr_branch_pc;
                        state_d = S_WAIT_COMMIT;
                    end
                end
                S_WAIT_COMMIT: begin
                    if (commit_hit) begin
                        redirect_valid_d = redir_flag_q;
                        redirect_pc_d    = redir_flag_q ? redir_pc_q : '0;
                        redir_flag_d     = 1'b0;
                        if (HOLDOFF_CYC == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            holdoff_cnt_d = HOLDOFF_W'(HOLDOFF_CYC);
                            state_d       = S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    holdoff_cnt_d = holdoff_cnt_q - 1'b1;
                    if (holdoff_cnt_q <= HOLDOFF_W'(1)) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy             = (state_q != S_IDLE);
        in_ready         = (state_q == S_IDLE) && !flush && !rst;
        csr_issue_valid  = (state_q == S_ISSUE) && !flush;
        csr_issue_ticket = csr_issue_valid ? ticket_q : '0;
        fe_stall         = busy || (in_valid && in_ready);
        redirect_valid   = redirect_valid_q;
        redirect_pc      = redirect_pc_q;
    end

endmodule

// File: tb/tb_csr_serializer.sv
// Directed bench for csr_serializer: a default-holdoff instance and a
// zero-holdoff instance share all inputs so their timing can be contrasted.
module tb_csr_serializer;

    localparam int TW = 3;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [TW-1:0] in_ticket;
    logic          rob_head_valid;
    logic [TW-1:0] rob_head_ticket;
    logic          csr_done;
    logic [TW-1:0] csr_done_ticket;
    logic          csr_branch;
    logic [PW-1:0] csr_branch_pc;
    logic          commit_valid;
    logic [TW-1:0] commit_ticket;

    logic          in_ready, csr_issue_valid, redirect_valid, fe_stall, busy;
    logic [TW-1:0] csr_issue_ticket;
    logic [PW-1:0] redirect_pc;

    logic          z_in_ready, z_csr_issue_valid, z_redirect_valid, z_fe_stall, z_busy;
    logic [TW-1:0] z_csr_issue_ticket;
    logic [PW-1:0] z_redirect_pc;

    int checks = 0;
    int errors = 0;
    int issue_total = 0;
    int redirect_total = 0;

    always #5 clk = ~clk;

    csr_serializer #(.TICKET_W(TW), .PC_W(PW), .HOLDOFF_CYC(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ticket(in_ticket),
        .rob_head_valid(rob_head_valid), .rob_head_ticket(rob_head_ticket),
        .csr_issue_valid(csr_issue_valid), .csr_issue_ticket(csr_issue_ticket),
        .csr_done(csr_done), .csr_done_ticket(csr_done_ticket),
        .csr_branch(csr_branch), .csr_branch_pc(csr_branch_pc),
        .commit_valid(commit_valid), .commit_ticket(commit_ticket),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fe_stall(fe_stall), .busy(busy)
    );

    csr_serializer #(.TICKET_W(TW), .PC_W(PW), .HOLDOFF_CYC(0)) dut_z (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_ticket(in_ticket),
        .rob_head_valid(rob_head_valid), .rob_head_ticket(rob_head_ticket),
        .csr_issue_valid(z_csr_issue_valid), .csr_issue_ticket(z_csr_issue_ticket),
        .csr_done(csr_done), .csr_done_ticket(csr_done_ticket),
        .csr_branch(csr_branch), .csr_branch_pc(csr_branch_pc),
        .commit_valid(commit_valid), .commit_ticket(commit_ticket),
        .redirect_valid(z_redirect_valid), .redirect_pc(z_redirect_pc),
        .fe_stall(z_fe_stall), .busy(z_busy)
    );

    always @(negedge clk) begin
        if (csr_issue_valid) issue_total++;
        if (redirect_valid) redirect_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_ticket = '0;
        rob_head_valid = 0; rob_head_ticket = '0;
        csr_done = 0; csr_done_ticket = '0; csr_branch = 0; csr_branch_pc = '0;
        commit_valid = 0; commit_ticket = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if ({busy, fe_stall, csr_issue_valid, redirect_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000", {busy, fe_stall, csr_issue_valid, redirect_valid}); end
        checks++; if (redirect_pc !== 32'h0 || csr_issue_ticket !== 3'd0) begin
            errors++; $display("FAIL reset_buses: pc %h ticket %0d want 0/0", redirect_pc, csr_issue_ticket); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_csr();
        int i0, r0;
        i0 = issue_total; r0 = redirect_total;
        step(); in_valid = 1; in_ticket = 3; #1;
        checks++; if (in_ready !== 1'b1 || fe_stall !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_accept: ready %b stall %b busy %b want 1 1 0", in_ready, fe_stall, busy); end
        step(); in_valid = 0; rob_head_valid = 1; rob_head_ticket = 3; #1;
        checks++; if (busy !== 1'b1 || fe_stall !== 1'b1 || csr_issue_valid !== 1'b0) begin
            errors++; $display("FAIL basic_wait_head: busy %b stall %b issue %b want 1 1 0", busy, fe_stall, csr_issue_valid); end
        step(); #1;
        checks++; if (csr_issue_valid !== 1'b1 || csr_issue_ticket !== 3'd3 || z_csr_issue_ticket !== 3'd3) begin
            errors++; $display("FAIL basic_issue: valid %b ticket %0d z_ticket %0d want 1 3 3", csr_issue_valid, csr_issue_ticket, z_csr_issue_ticket); end
        rob_head_valid = 0;
        step(); csr_done = 1; csr_done_ticket = 3; #1;
        checks++; if (csr_issue_valid !== 1'b0) begin errors++; $display("FAIL basic_issue_once: got %b want 0", csr_issue_valid); end
        step(); csr_done = 0;
        step(); commit_valid = 1; commit_ticket = 3; #1;
        checks++; if (fe_stall !== 1'b1) begin errors++; $display("FAIL basic_commit_stall: got %b want 1", fe_stall); end
        step(); commit_valid = 0; #1;
        checks++; if (fe_stall !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL basic_holdoff1: stall %b busy %b redir %b want 1 1 0", fe_stall, busy, redirect_valid); end
        checks++; if (z_busy !== 1'b0 || z_in_ready !== 1'b1 || z_fe_stall !== 1'b0) begin
            errors++; $display("FAIL zero_holdoff_idle: busy %b ready %b stall %b want 0 1 0", z_busy, z_in_ready, z_fe_stall); end
        step(); #1;
        checks++; if (fe_stall !== 1'b1) begin errors++; $display("FAIL basic_holdoff2: got %b want 1", fe_stall); end
        step(); #1;
        checks++; if (busy !== 1'b0 || fe_stall !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_idle: busy %b stall %b ready %b want 0 0 1", busy, fe_stall, in_ready); end
        checks++; if (issue_total - i0 !== 1 || redirect_total - r0 !== 0) begin
            errors++; $display("FAIL basic_pulses: issues %0d redirects %0d want 1 0", issue_total - i0, redirect_total - r0); end
    endtask

    task automatic test_head_wait();
        int i0;
        i0 = issue_total;
        step(); in_valid = 1; in_ticket = 5; rob_head_valid = 1; rob_head_ticket = 4;
        step(); in_valid = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (csr_issue_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL head_wait_%0d: issue %b busy %b want 0 1", i, csr_issue_valid, busy); end
            step();
        end
        rob_head_ticket = 5;
        step(); #1;
        checks++; if (csr_issue_valid !== 1'b1 || csr_issue_ticket !== 3'd5) begin
            errors++; $display("FAIL head_issue: valid %b ticket %0d want 1 5", csr_issue_valid, csr_issue_ticket); end
        rob_head_valid = 0;
        csr_done = 1; csr_done_ticket = 5;
        step(); csr_done = 0; commit_valid = 1; commit_ticket = 5;
        step(); commit_valid = 0;
        step(); step(); #1;
        checks++; if (busy !== 1'b0 || issue_total - i0 !== 1) begin
            errors++; $display("FAIL zero_latency_done: busy %b issues %0d want 0 1", busy, issue_total - i0); end
    endtask

    task automatic test_mret_redirect();
        int r0;
        r0 = redirect_total;
        step(); in_valid = 1; in_ticket = 2; rob_head_valid = 1; rob_head_ticket = 2;
        step(); in_valid = 0;
        step(); rob_head_valid = 0;
        step(); csr_done = 1; csr_done_ticket = 2; csr_branch = 1; csr_branch_pc = 32'h0000_0200;
        step(); csr_done = 0; csr_branch = 0; csr_branch_pc = '0; #1;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mret_early: got %b want 0", redirect_valid); end
        commit_valid = 1; commit_ticket = 2;
        step(); commit_valid = 0; #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200 || z_redirect_pc !== 32'h0000_0200) begin
            errors++; $display("FAIL mret_redirect: valid %b pc %h z_pc %h want 1 00000200", redirect_valid, redirect_pc, z_redirect_pc); end
        step(); #1;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mret_one_cycle: got %b want 0", redirect_valid); end
        step(); #1;
        checks++; if (busy !== 1'b0 || redirect_total - r0 !== 1) begin
            errors++; $display("FAIL mret_done: busy %b redirects %0d want 0 1", busy, redirect_total - r0); end
    endtask

    task automatic test_flush();
        int r0;
        r0 = redirect_total;
        step(); in_valid = 1; in_ticket = 1; rob_head_valid = 1; rob_head_ticket = 1;
        step(); in_valid = 0;
        step(); flush = 1; #1;
        checks++; if (csr_issue_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_issue: issue %b ready %b want 0 0", csr_issue_valid, in_ready); end
        step(); flush = 0; rob_head_valid = 0; #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_issue_idle: busy %b ready %b want 0 1", busy, in_ready); end
        in_valid = 1; in_ticket = 6; rob_head_valid = 1; rob_head_ticket = 6;
        step(); in_valid = 0;
        step(); rob_head_valid = 0;
        step(); flush = 1;
        step(); flush = 0; csr_done = 1; csr_done_ticket = 6; csr_branch = 1; csr_branch_pc = 32'h0000_0444; #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_wait_res: busy %b ready %b want 0 1", busy, in_ready); end
        step(); csr_done = 0; csr_branch = 0; csr_branch_pc = '0; commit_valid = 1; commit_ticket = 6;
        step(); commit_valid = 0; #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_total - r0 !== 0) begin
            errors++; $display("FAIL flush_late_done: busy %b redir %b count %0d want 0 0 0", busy, redirect_valid, redirect_total - r0); end
    endtask

    task automatic test_wrong_ticket();
        int r0;
        r0 = redirect_total;
        step(); in_valid = 1; in_ticket = 1; rob_head_valid = 1; rob_head_ticket = 1;
        step(); in_valid = 0;
        step(); rob_head_valid = 0;
        step(); csr_done = 1; csr_done_ticket = 6; csr_branch = 1; csr_branch_pc = 32'h0000_0004;
        step(); csr_done_ticket = 1; csr_branch = 0; csr_branch_pc = '0;
        step(); csr_done = 0; commit_valid = 1; commit_ticket = 6;
        step(); commit_ticket = 1;
        step(); commit_valid = 0;
        step(); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrong_commit_ignored: busy %b want 1", busy); end
        step(); #1;
        checks++; if (busy !== 1'b0 || redirect_total - r0 !== 0) begin
            errors++; $display("FAIL wrong_done_ignored: busy %b redirects %0d want 0 0", busy, redirect_total - r0); end
    endtask

    task automatic test_flush_keeps_redirect();
        step(); in_valid = 1; in_ticket = 7; rob_head_valid = 1; rob_head_ticket = 7;
        step(); in_valid = 0;
        step(); rob_head_valid = 0; csr_done = 1; csr_done_ticket = 7; csr_branch = 1; csr_branch_pc = 32'h0000_0300;
        step(); csr_done = 0; csr_branch = 0; csr_branch_pc = '0; commit_valid = 1; commit_ticket = 7;
        step(); commit_valid = 0; flush = 1; #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0300) begin
            errors++; $display("FAIL flush_keeps_redirect: valid %b pc %h want 1 00000300", redirect_valid, redirect_pc); end
        step(); flush = 0; #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL flush_holdoff: busy %b redir %b want 0 0", busy, redirect_valid); end
    endtask

    task automatic test_reset_mid();
        step(); in_valid = 1; in_ticket = 4; rob_head_valid = 1; rob_head_ticket = 4;
        step(); in_valid = 0;
        step(); rob_head_valid = 0; csr_done = 1; csr_done_ticket = 4; csr_branch = 1; csr_branch_pc = 32'h0000_0088;
        step(); csr_done = 0; csr_branch = 0; csr_branch_pc = '0;
        rst = 1; #1;
        checks++; if ({busy, fe_stall, in_ready, csr_issue_valid, redirect_valid, z_busy} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b want 000000", {busy, fe_stall, in_ready, csr_issue_valid, redirect_valid, z_busy}); end
        @(negedge clk); rst = 0; #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_release: ready %b busy %b want 1 0", in_ready, busy); end
        commit_valid = 1; commit_ticket = 4;
        step(); commit_valid = 0; #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_commit: busy %b redir %b want 0 0", busy, redirect_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_csr();
        test_head_wait();
        test_mret_redirect();
        test_flush();
        test_wrong_ticket();
        test_flush_keeps_redirect();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
